// File: rtl/spike_frame_fetcher.sv
// Read-side sequencer for the input spike RAM.
// Streams num_frames consecutive RAM words from base_addr over a valid/ready
// interface. A 2-entry output FIFO plus a single inflight read slot hides the
// 1-cycle RAM latency, so a frame can be delivered every cycle.
module spike_frame_fetcher #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 1002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_frames,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_qin,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [DATA_W-1:0] spk_data,
  output logic              spk_last,
  output logic [15:0]       spk_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       nf_q;
  logic [15:0]       issued_q;
  logic              inflight_q;
  logic [15:0]       inflight_idx_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [15:0]       fifo_idx_q  [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic       pop, push, issue, start_run, flush;
  logic [2:0] occ_sum, credit_used;

  assign pop       = spk_valid & spk_ready;
  assign push      = inflight_q;
  assign start_run = (state_q == StIdle) & start & ~abort;
  assign flush     = (state_q != StIdle) & abort;

  // Occupancy already committed to the FIFO once this cycle's pop retires.
  assign occ_sum     = 3'(count_q) + 3'(inflight_q);
  assign credit_used = occ_sum - 3'(pop);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks everything else outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = (num_frames == 16'd0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (issue && (issued_q + 16'd1 == nf_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (count_q == 2'd0 && !inflight_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs and read-issue decision.
  always_comb begin
    busy  = (state_q != StIdle);
    done  = (state_q == StFin);
    issue = (state_q == StRun) && !abort && (issued_q != nf_q) && (credit_used < 3'd2);
  end

  // Run parameters, read address/counters, inflight slot and FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      nf_q           <= '0;
      issued_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_idx_q[0]  <= '0;
      fifo_idx_q[1]  <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else if (flush) begin
      // Drop queued frames and the read still in flight.
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (start_run) begin
        addr_q   <= ADDR_W'(base_addr % ADDR_W'(DEPTH));
        nf_q     <= num_frames;
        issued_q <= '0;
      end
      if (issue) begin
        addr_q         <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        issued_q       <= issued_q + 16'd1;
        inflight_idx_q <= issued_q;
      end
      inflight_q <= issue;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_data_out;
        fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // The RAM sees the current read address directly so its data lands one edge
  // after the issue cycle.
  assign ram_address = addr_q;
  assign ram_we      = 1'b0;
  assign ram_qin     = '0;

  assign spk_valid = (count_q != 2'd0);
  assign spk_data  = fifo_data_q[rd_ptr_q];
  assign spk_index = fifo_idx_q[rd_ptr_q];
  assign spk_last  = spk_valid && (fifo_idx_q[rd_ptr_q] == nf_q - 16'd1);

endmodule
